multicycle_main_fsm: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 62 ++++++
 rtl/opcode_class_decode.sv | 34 +++
 rtl/multicycle_main_fsm.sv | 166 ++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RISC-V core: FSM state
// encoding, opcode constants, datapath select encodings and the opcode class.
package riscv_ctrl_pkg;

    // 4-bit state encoding; FETCH must stay at zero so reset lands there
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StLui      = 4'd11
    } state_e;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Result mux select
    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    // ALU A select; ZERO is only ever driven when LUI support is built in
    localparam logic [1:0] ALUSRCA_PC    = 2'b00;
    localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
    localparam logic [1:0] ALUSRCA_RS1   = 2'b10;
    localparam logic [1:0] ALUSRCA_ZERO  = 2'b11;

    // ALU B select
    localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

    // ALU decoder class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // One-hot opcode class
    typedef struct packed {
        logic mem;
        logic r;
        logic i;
        logic jal;
        logic beq;
        logic lui;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier shared by the DECODE and MEMADR decisions.
// Optional feature macro: MULTICYCLE_FSM_LUI_EN (recognise LUI as legal).
module opcode_class_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 7
) (
    input  logic [OP_WIDTH-1:0] op,
    output op_class_t           op_class,
    output logic                is_load
);

    // Map opcode to exactly one class; anything unrecognised is illegal
    always_comb begin
        op_class = '0;
        case (op)
            OP_LW, OP_SW: op_class.mem = 1'b1;
            OP_R:         op_class.r   = 1'b1;
            OP_I:         op_class.i   = 1'b1;
            OP_JAL:       op_class.jal = 1'b1;
            OP_BEQ:       op_class.beq = 1'b1;
`ifdef MULTICYCLE_FSM_LUI_EN
            OP_LUI:       op_class.lui = 1'b1;
`endif
            default:      op_class.illegal = 1'b1;
        endcase
    end

    // Load vs store split inside the memory class
    always_comb begin
        is_load = (op == OP_LW);
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RISC-V core. Moore outputs decoded from
// the state register; only FETCH/MEMREAD/MEMWRITE look at mem_ready.
// Optional feature macro: MULTICYCLE_FSM_LUI_EN (adds the LUI state).
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                mem_ready,
    output logic                branch,
    output logic                pc_update,
    output logic                reg_write,
    output logic                mem_write,
    output logic                ir_write,
    output logic                adr_src,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                illegal_instr
);

    state_e    state_q, state_d;
    op_class_t op_class;
    logic      is_load;

    opcode_class_decode #(
        .OP_WIDTH (OP_WIDTH)
    ) u_opcode_class_decode (
        .op       (op),
        .op_class (op_class),
        .is_load  (is_load)
    );

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d       = StFetch;
        branch        = 1'b0;
        pc_update     = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;

        case (state_q)
            StFetch: begin
                adr_src    = 1'b0;
                alu_src_a  = ALUSRCA_PC;
                alu_src_b  = ALUSRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RESULT_ALU;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Precompute the branch target while the opcode is classified
                alu_src_a = ALUSRCA_OLDPC;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_ADD;
                if (op_class.mem) begin
                    state_d = StMemAdr;
                end else if (op_class.r) begin
                    state_d = StExecuteR;
                end else if (op_class.i) begin
                    state_d = StExecuteI;
                end else if (op_class.jal) begin
                    state_d = StJal;
                end else if (op_class.beq) begin
                    state_d = StBeq;
`ifdef MULTICYCLE_FSM_LUI_EN
                end else if (op_class.lui) begin
                    state_d = StLui;
`endif
                end else begin
                    illegal_instr = 1'b1;
                    state_d       = StFetch;
                end
            end
            StMemAdr: begin
                alu_src_a = ALUSRCA_RS1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = is_load ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
                state_d    = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                result_src = RESULT_DATA;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                // Strobe held until memory accepts the write
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
                mem_write  = 1'b1;
                state_d    = mem_ready ? StFetch : StMemWrite;
            end
            StExecuteR: begin
                alu_src_a = ALUSRCA_RS1;
                alu_src_b = ALUSRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = StAluWb;
            end
            StExecuteI: begin
                alu_src_a = ALUSRCA_RS1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = RESULT_ALUOUT;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                alu_src_a  = ALUSRCA_OLDPC;
                alu_src_b  = ALUSRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RESULT_ALUOUT;
                pc_update  = 1'b1;
                state_d    = StAluWb;
            end
            StBeq: begin
                alu_src_a  = ALUSRCA_RS1;
                alu_src_b  = ALUSRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RESULT_ALUOUT;
                branch     = 1'b1;
                state_d    = StFetch;
            end
`ifdef MULTICYCLE_FSM_LUI_EN
            StLui: begin
                alu_src_a = ALUSRCA_ZERO;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = StAluWb;
            end
`endif
            // Unused encodings fall back to FETCH with all strobes low
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm. Expected output vectors are
// queued per instruction and popped one per cycle as the DUT is sampled.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       branch, pc_update, reg_write, mem_write, ir_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal_instr;

    int total = 0;
    int bad   = 0;

    logic [14:0] exp_q[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;

    multicycle_main_fsm #(
        .OP_WIDTH (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .mem_ready     (mem_ready),
        .branch        (branch),
        .pc_update     (pc_update),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .adr_src       (adr_src),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {br,pc,rw,mw,ir,adr,res[2],a[2],b[2],aop[2],ill}
    logic [14:0] obs;
    always_comb begin
        obs = {branch, pc_update, reg_write, mem_write, ir_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};
    end

    function automatic logic [14:0] vec(input logic br, input logic pc, input logic rw,
                                        input logic mw, input logic ir, input logic ad,
                                        input logic [1:0] rs, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [1:0] ao,
                                        input logic il);
        return {br, pc, rw, mw, ir, ad, rs, sa, sb, ao, il};
    endfunction

    function automatic logic [14:0] v_fetch(input logic mr);
        return vec(0, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    endfunction
    function automatic logic [14:0] v_decode(input logic il);
        return vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, il);
    endfunction
    localparam logic [14:0] V_MEMADR = 15'b000000_00_10_01_00_0;
    localparam logic [14:0] V_MEMRD  = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] V_MEMWB  = 15'b001000_01_00_00_00_0;
    localparam logic [14:0] V_MEMWR  = 15'b000101_00_00_00_00_0;
    localparam logic [14:0] V_EXR    = 15'b000000_00_10_00_10_0;
    localparam logic [14:0] V_EXI    = 15'b000000_00_10_01_10_0;
    localparam logic [14:0] V_ALUWB  = 15'b001000_00_00_00_00_0;
    localparam logic [14:0] V_JAL    = 15'b010000_00_01_10_00_0;
    localparam logic [14:0] V_BEQ    = 15'b100000_00_10_00_01_0;
    localparam logic [14:0] V_LUI    = 15'b000000_00_11_01_00_0;

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then compare 1 ns later
    task automatic step(input string tag, input logic [6:0] o, input logic mr,
                        input logic rst);
        logic [14:0] exp;
        @(negedge clk);
        op        = o;
        mem_ready = mr;
        reset     = rst;
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %b required an entry", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, obs, exp);
        end
    endtask

    // Straight-line instruction with mem_ready held high
    task automatic run_simple(input string tag, input logic [6:0] o);
        exp_q.push_back(v_fetch(1'b1));
        exp_q.push_back(v_decode(1'b0));
        case (o)
            RT:  begin exp_q.push_back(V_EXR); exp_q.push_back(V_ALUWB); end
            IT:  begin exp_q.push_back(V_EXI); exp_q.push_back(V_ALUWB); end
            JAL: begin exp_q.push_back(V_JAL); exp_q.push_back(V_ALUWB); end
            BEQ: exp_q.push_back(V_BEQ);
            SW:  begin exp_q.push_back(V_MEMADR); exp_q.push_back(V_MEMWR); end
            default: ;
        endcase
        while (exp_q.size() > 0) step(tag, o, 1'b1, 1'b0);
    endtask

    task automatic run_lw(input string tag, input int stalls);
        exp_q.push_back(v_fetch(1'b1));
        exp_q.push_back(v_decode(1'b0));
        exp_q.push_back(V_MEMADR);
        for (int k = 0; k <= stalls; k++) exp_q.push_back(V_MEMRD);
        exp_q.push_back(V_MEMWB);
        step(tag, LW, 1'b1, 1'b0);
        step(tag, LW, 1'b1, 1'b0);
        step(tag, LW, 1'b1, 1'b0);
        // op wiggles during the stall must not disturb the load
        for (int k = 0; k < stalls; k++) step({tag, "_stall"}, SW, 1'b0, 1'b0);
        step(tag, LW, 1'b1, 1'b0);
        step({tag, "_wb"}, LW, 1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        op        = 7'd0;
        mem_ready = 1'b0;

        // Reset state
        exp_q.push_back(v_fetch(1'b0));
        exp_q.push_back(v_fetch(1'b1));
        step("reset_fetch_nr", 7'd0, 1'b0, 1'b1);
        step("reset_fetch_r", 7'd0, 1'b1, 1'b1);

        // Fetch stall then lw without stalls
        exp_q.push_back(v_fetch(1'b0));
        step("fetch_stall", LW, 1'b0, 1'b0);
        run_lw("lw", 0);
        run_lw("lw_wait", 3);

        run_simple("rtype", RT);
        run_simple("beq", BEQ);
        run_simple("itype", IT);
        run_simple("jal", JAL);
        run_simple("sw", SW);

        // Illegal opcodes, including LUI when not built in
        exp_q.push_back(v_fetch(1'b1));
        exp_q.push_back(v_decode(1'b1));
        step("illegal", 7'b1111111, 1'b1, 1'b0);
        step("illegal_dec", 7'b1111111, 1'b1, 1'b0);

        exp_q.push_back(v_fetch(1'b1));
`ifdef MULTICYCLE_FSM_LUI_EN
        exp_q.push_back(v_decode(1'b0));
        exp_q.push_back(V_LUI);
        exp_q.push_back(V_ALUWB);
        step("lui", LUI, 1'b1, 1'b0);
        step("lui_dec", LUI, 1'b1, 1'b0);
        step("lui_state", LUI, 1'b1, 1'b0);
        step("lui_wb", LUI, 1'b1, 1'b0);
`else
        exp_q.push_back(v_decode(1'b1));
        step("lui_off", LUI, 1'b1, 1'b0);
        step("lui_off_dec", LUI, 1'b1, 1'b0);
`endif

        // Reset held two cycles while stuck in MEMWRITE
        exp_q.push_back(v_fetch(1'b1));
        exp_q.push_back(v_decode(1'b0));
        exp_q.push_back(V_MEMADR);
        exp_q.push_back(V_MEMWR);
        exp_q.push_back(V_MEMWR);
        exp_q.push_back(v_fetch(1'b0));
        exp_q.push_back(v_fetch(1'b0));
        exp_q.push_back(v_fetch(1'b1));
        step("sw_rst", SW, 1'b1, 1'b0);
        step("sw_rst", SW, 1'b1, 1'b0);
        step("sw_rst", SW, 1'b1, 1'b0);
        step("sw_rst_wait", SW, 1'b0, 1'b0);
        step("sw_rst_assert", SW, 1'b0, 1'b1);
        step("rst_in_memwrite", SW, 1'b0, 1'b1);
        step("post_reset_fetch", SW, 1'b0, 1'b0);
        step("post_reset_go", SW, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
